// File: rtl/lockable_reg_bank_pkg.sv
// Shared types for the lockable register bank: handshake FSM states and response classes.
package lockable_reg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   // Why a request gets the response it does; anything other than RSP_OK raises rsp_err.
   typedef enum logic [1:0] {
      RSP_OK       = 2'd0,
      RSP_LOCKED   = 2'd1,
      RSP_BAD_ADDR = 2'd2
   } rsp_kind_t;

endpackage

// File: rtl/lockable_reg_bank_if.sv
// Valid/ready request/response port between the config bus adapter and the register bank.
interface lockable_reg_bank_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/lockable_reg_bank_slice.sv
// One data register with its sticky lock bit; a write is dropped while the effective lock holds.
module lock_reg_slice #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              Clk,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              lock_set,
   input  logic              override,
   output logic [DATA_W-1:0] data,
   output logic              locked,
   output logic              blocked
);

   logic eff_lock;

   // A lock requested in the same cycle as a write already protects that write.
   assign eff_lock = locked | lock_set;
   assign blocked  = wr_en & eff_lock & ~override;

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         locked <= 1'b0;
      end else if (lock_set) begin
         locked <= 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         data <= RESET_VAL;
      end else if (wr_en && !blocked) begin
         data <= wdata;
      end
   end

endmodule

// File: rtl/lockable_reg_bank.sv
// Bank of NUM_REGS lockable registers behind a valid/ready port; rejected writes are flagged and counted.
module lockable_reg_bank #(
   parameter int                DATA_W         = 32,
   parameter int                NUM_REGS       = 4,
   parameter int                ADDR_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   parameter logic [DATA_W-1:0] RESET_VAL      = '0,
   parameter int                DEBUG_OVERRIDE = 0,
   parameter int                VIOL_CNT_W     = 8
) (
   input  logic                       Clk,
   input  logic                       resetn,
   lockable_reg_bank_if.slave         bus,
   input  logic [NUM_REGS-1:0]        lock_set,
   input  logic                       debug_unlocked,
   output logic [NUM_REGS-1:0]        lock_status,
   output logic [NUM_REGS*DATA_W-1:0] Data_out,
   output logic [VIOL_CNT_W-1:0]      viol_count
);
   import lockable_reg_pkg::*;

   state_t            state;
   state_t            next_state;
   rsp_kind_t         rsp_kind;
   logic              accept;
   logic              addr_ok;
   logic              override;
   logic              blocked_any;
   logic [NUM_REGS-1:0] wr_hit;
   logic [NUM_REGS-1:0] blocked;
   logic [DATA_W-1:0] slice_data [NUM_REGS];
   logic [DATA_W-1:0] rd_data;

   assign accept  = bus.req_valid & bus.req_ready;
   assign addr_ok = int'(bus.req_addr) < NUM_REGS;
   // Production builds tie the bypass off at elaboration, so debug_unlocked cannot reach the gates.
   assign override = (DEBUG_OVERRIDE != 0) && debug_unlocked;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
      assign wr_hit[i] = accept & bus.req_write & addr_ok & (bus.req_addr == ADDR_W'(i));

      lock_reg_slice #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_slice (
         .Clk      (Clk),
         .resetn   (resetn),
         .wr_en    (wr_hit[i]),
         .wdata    (bus.req_wdata),
         .lock_set (lock_set[i]),
         .override (override),
         .data     (slice_data[i]),
         .locked   (lock_status[i]),
         .blocked  (blocked[i])
      );

      assign Data_out[i*DATA_W +: DATA_W] = slice_data[i];
   end

   assign blocked_any = |blocked;

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.req_addr == ADDR_W'(i)) begin
            rd_data = slice_data[i];
         end
      end
   end

   always_comb begin
      rsp_kind = RSP_OK;
      if (!addr_ok) begin
         rsp_kind = RSP_BAD_ADDR;
      end else if (blocked_any) begin
         rsp_kind = RSP_LOCKED;
      end
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.req_valid) next_state = RESP;
         RESP:    if (bus.rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE:    bus.req_ready = 1'b1;
         RESP:    bus.rsp_valid = 1'b1;
         default: bus.req_ready = 1'b0;
      endcase
   end

   // Response is captured at acceptance and held untouched while the consumer stalls.
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else if (accept) begin
         bus.rsp_err   <= (rsp_kind != RSP_OK);
         bus.rsp_rdata <= (!bus.req_write && rsp_kind == RSP_OK) ? rd_data : '0;
      end
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         viol_count <= '0;
      end else if (accept && rsp_kind == RSP_LOCKED && viol_count != '1) begin
         viol_count <= viol_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Directed bench: a production bank (4 regs, no override) and a debug bank (3 regs, override enabled).
module tb_lockable_reg_bank;

   logic        Clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   logic [3:0]  lock_set = '0;
   logic        debug_unlocked = 1'b0;

   logic [3:0]   ls0;
   logic [2:0]   ls1;
   logic [127:0] d0;
   logic [95:0]  d1;
   logic [7:0]   v0;
   logic [7:0]   v1;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   lockable_reg_bank_if #(.DATA_W(32), .ADDR_W(2)) if0 ();
   lockable_reg_bank_if #(.DATA_W(32), .ADDR_W(2)) if1 ();

   assign if0.req_valid = req_valid & ~sel;
   assign if1.req_valid = req_valid & sel;
   assign if0.req_write = req_write;
   assign if1.req_write = req_write;
   assign if0.req_addr  = req_addr;
   assign if1.req_addr  = req_addr;
   assign if0.req_wdata = req_wdata;
   assign if1.req_wdata = req_wdata;
   assign if0.rsp_ready = rsp_ready;
   assign if1.rsp_ready = rsp_ready;

   lockable_reg_bank #(.DATA_W(32), .NUM_REGS(4), .DEBUG_OVERRIDE(0), .VIOL_CNT_W(8)) dut0 (
      .Clk            (Clk),
      .resetn         (resetn),
      .bus            (if0),
      .lock_set       (sel ? 4'b0000 : lock_set),
      .debug_unlocked (debug_unlocked),
      .lock_status    (ls0),
      .Data_out       (d0),
      .viol_count     (v0)
   );

   lockable_reg_bank #(.DATA_W(32), .NUM_REGS(3), .DEBUG_OVERRIDE(1), .VIOL_CNT_W(8)) dut1 (
      .Clk            (Clk),
      .resetn         (resetn),
      .bus            (if1),
      .lock_set       (sel ? lock_set[2:0] : 3'b000),
      .debug_unlocked (debug_unlocked),
      .lock_status    (ls1),
      .Data_out       (d1),
      .viol_count     (v1)
   );

   logic         o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0]  o_rsp_rdata;
   logic [3:0]   o_locks;
   logic [127:0] o_data;
   logic [7:0]   o_viol;

   assign o_req_ready = sel ? if1.req_ready : if0.req_ready;
   assign o_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
   assign o_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;
   assign o_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
   assign o_locks     = sel ? {1'b0, ls1}   : ls0;
   assign o_data      = sel ? {32'h0, d1}   : d0;
   assign o_viol      = sel ? v1            : v0;

   typedef struct {
      logic        sel;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  ls;
      logic        dbg;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [7:0]  exp_viol;
      logic [3:0]  exp_locks;
      logic [31:0] exp_reg;
   } vec_t;

   vec_t        vecs[$];
   logic        obs_err;
   logic [31:0] obs_rdata;

   function automatic vec_t mk(input logic s, input logic wr, input logic [1:0] a,
                               input logic [31:0] wd, input logic [3:0] ls, input logic dbg,
                               input logic e, input logic [31:0] rd, input logic [7:0] vc,
                               input logic [3:0] lk, input logic [31:0] rg);
      vec_t v;
      v.sel = s; v.wr = wr; v.addr = a; v.wdata = wd; v.ls = ls; v.dbg = dbg;
      v.exp_err = e; v.exp_rdata = rd; v.exp_viol = vc; v.exp_locks = lk; v.exp_reg = rg;
      return v;
   endfunction

   function automatic logic [31:0] slotOf(input logic [127:0] d, input logic [1:0] a);
      return d[int'(a)*32 +: 32];
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full request/response: returns at the negedge where the response is visible.
   task automatic applyStimulus(input vec_t v);
      int n;
      @(negedge Clk);
      sel = v.sel; req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
      req_wdata = v.wdata; lock_set = v.ls; debug_unlocked = v.dbg; rsp_ready = 1'b1;
      #1;
      n = 0;
      while (!o_req_ready && n < 10) begin
         @(negedge Clk);
         n++;
      end
      checkOutput("req_ready before accept", o_req_ready, 1);
      @(posedge Clk);
      @(negedge Clk);
      req_valid = 1'b0; lock_set = '0; debug_unlocked = 1'b0;
      n = 0;
      while (!o_rsp_valid && n < 10) begin
         @(negedge Clk);
         n++;
      end
      checkOutput("rsp_valid after accept", o_rsp_valid, 1);
      obs_err   = o_rsp_err;
      obs_rdata = o_rsp_rdata;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t sat;

      vecs.push_back(mk(0, 1, 2, 32'hA5A5_0001, 4'b0000, 0, 0, 32'h0,         8'd0, 4'b0000, 32'hA5A5_0001));
      vecs.push_back(mk(0, 0, 2, 32'h0,         4'b0000, 0, 0, 32'hA5A5_0001, 8'd0, 4'b0000, 32'hA5A5_0001));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0F0F, 4'b0000, 0, 0, 32'h0,         8'd0, 4'b0000, 32'h0000_0F0F));
      vecs.push_back(mk(0, 0, 3, 32'h0,         4'b0100, 0, 0, 32'h0,         8'd0, 4'b0100, 32'h0));
      vecs.push_back(mk(0, 1, 2, 32'hDEAD_BEEF, 4'b0000, 0, 1, 32'h0,         8'd1, 4'b0100, 32'hA5A5_0001));
      vecs.push_back(mk(0, 1, 1, 32'h0000_1234, 4'b0010, 0, 1, 32'h0,         8'd2, 4'b0110, 32'h0));
      vecs.push_back(mk(0, 1, 2, 32'hCAFE_F00D, 4'b0000, 1, 1, 32'h0,         8'd3, 4'b0110, 32'hA5A5_0001));
      vecs.push_back(mk(0, 0, 2, 32'h0,         4'b0000, 0, 0, 32'hA5A5_0001, 8'd3, 4'b0110, 32'hA5A5_0001));
      vecs.push_back(mk(0, 0, 0, 32'h0,         4'b0000, 0, 0, 32'h0000_0F0F, 8'd3, 4'b0110, 32'h0000_0F0F));
      vecs.push_back(mk(0, 1, 3, 32'h0000_7777, 4'b0000, 0, 0, 32'h0,         8'd3, 4'b0110, 32'h0000_7777));
      vecs.push_back(mk(1, 1, 2, 32'h1111_2222, 4'b0100, 0, 1, 32'h0,         8'd1, 4'b0100, 32'h0));
      vecs.push_back(mk(1, 1, 2, 32'h3333_4444, 4'b0000, 1, 0, 32'h0,         8'd1, 4'b0100, 32'h3333_4444));
      vecs.push_back(mk(1, 1, 3, 32'h5555_5555, 4'b0000, 0, 1, 32'h0,         8'd1, 4'b0100, 32'h0));
      vecs.push_back(mk(1, 0, 3, 32'h0,         4'b0000, 0, 1, 32'h0,         8'd1, 4'b0100, 32'h0));
      vecs.push_back(mk(1, 0, 2, 32'h0,         4'b0000, 0, 0, 32'h3333_4444, 8'd1, 4'b0100, 32'h3333_4444));

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      resetn = 1'b1;
      #1;
      checkOutput("reset data0", d0, 128'h0);
      checkOutput("reset data1", {32'h0, d1}, 128'h0);
      checkOutput("reset locks0", ls0, 0);
      checkOutput("reset locks1", ls1, 0);
      checkOutput("reset viol0", v0, 0);
      checkOutput("reset viol1", v1, 0);
      checkOutput("reset rsp_valid0", if0.rsp_valid, 0);
      checkOutput("reset rsp_valid1", if1.rsp_valid, 0);
      checkOutput("reset req_ready0", if0.req_ready, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d rsp_err", i), obs_err, vecs[i].exp_err);
         checkOutput($sformatf("v%0d rsp_rdata", i), obs_rdata, vecs[i].exp_rdata);
         checkOutput($sformatf("v%0d viol_count", i), o_viol, vecs[i].exp_viol);
         checkOutput($sformatf("v%0d lock_status", i), o_locks, vecs[i].exp_locks);
         if (!(vecs[i].sel && vecs[i].addr == 2'd3))
            checkOutput($sformatf("v%0d reg", i), slotOf(o_data, vecs[i].addr), vecs[i].exp_reg);
      end

      // Stalled response: outputs frozen, no new request taken even though one is offered.
      @(negedge Clk);
      sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3; rsp_ready = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      req_write = 1'b1; req_wdata = 32'h0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("hold%0d rsp_valid", k), o_rsp_valid, 1);
         checkOutput($sformatf("hold%0d rsp_rdata", k), o_rsp_rdata, 32'h0000_7777);
         checkOutput($sformatf("hold%0d req_ready", k), o_req_ready, 0);
         @(negedge Clk);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge Clk);
      checkOutput("release rsp_valid", o_rsp_valid, 0);
      checkOutput("release req_ready", o_req_ready, 1);
      checkOutput("release reg3 kept", slotOf(o_data, 2'd3), 32'h0000_7777);

      // Standalone lock pulse with no request in flight.
      @(negedge Clk);
      lock_set = 4'b0001;
      @(negedge Clk);
      lock_set = 4'b0000;
      repeat (3) @(negedge Clk);
      checkOutput("lock pulse sticky", o_locks, 4'b0111);

      // 300 locked writes: 3 + 251 = 254, then the counter pins at 255.
      sat = mk(0, 1, 0, 32'hFFFF_FFFF, 4'b0000, 0, 1, 32'h0, 8'd0, 4'b0111, 32'h0000_0F0F);
      for (int k = 0; k < 251; k++) applyStimulus(sat);
      checkOutput("viol before saturation", o_viol, 8'd254);
      for (int k = 0; k < 49; k++) applyStimulus(sat);
      checkOutput("viol saturated", o_viol, 8'd255);
      checkOutput("sat rsp_err", obs_err, 1);
      checkOutput("sat reg0 kept", slotOf(o_data, 2'd0), 32'h0000_0F0F);

      // Reset arriving while a response is stalled.
      @(negedge Clk);
      sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; rsp_ready = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      req_valid = 1'b0;
      checkOutput("pre-reset rsp_valid", o_rsp_valid, 1);
      #2 resetn = 1'b0;
      #1;
      checkOutput("midreset rsp_valid", o_rsp_valid, 0);
      checkOutput("midreset data", d0, 128'h0);
      checkOutput("midreset locks", ls0, 0);
      checkOutput("midreset viol", v0, 0);
      checkOutput("midreset rsp_err", if0.rsp_err, 0);
      @(negedge Clk);
      resetn = 1'b1; rsp_ready = 1'b1;
      #1;
      checkOutput("post-reset req_ready", o_req_ready, 1);
      applyStimulus(mk(0, 1, 0, 32'h0000_ABCD, 4'b0000, 0, 0, 32'h0, 8'd0, 4'b0000, 32'h0000_ABCD));
      checkOutput("post-reset write err", obs_err, 0);
      checkOutput("post-reset reg0", slotOf(o_data, 2'd0), 32'h0000_ABCD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
